sc_ifetch: RTL

Instruction-fetch and next-PC stage for the single-cycle MIPS core. It sits directly upstream of the main decoder/control unit.
- Holds the PC and fetches from an instruction memory that may insert wait states.
- Presents a stable instruction word to the decoder.
- Advances the PC with the decoder's 2-bit pcsource select when the instruction commits.

---
 rtl/sc_ifetch.sv | 80 ++++++++
 1 files changed

// File: rtl/sc_ifetch.sv
// sc_ifetch: PC register, wait-state tolerant instruction fetch and next-PC select for the single-cycle core.
module sc_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] icount,
    output logic        misalign
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
    state_t      r_state;
    logic        r_req;
    logic        r_inst_valid;
    logic        r_misalign;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_icount;
    logic [31:0] w_next_pc;
    always_comb begin
        w_next_pc = pcsource[1] ? (pcsource[0] ? jpc : da) : (pcsource[0] ? bpc : pc4);
    end
    assign pc4        = r_pc + 32'd4;
    assign pc         = r_pc;
    assign imem_addr  = r_pc;
    assign imem_req   = r_req;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign icount     = r_icount;
    assign misalign   = r_misalign;
    // imem_req is registered alongside the state so it is glitch-free toward memory
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_icount     <= '0;
            r_misalign   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: if (imem_ready) begin
                    r_inst       <= imem_rdata;
                    r_inst_valid <= 1'b1;
                    r_req        <= 1'b0;
                    r_state      <= S_EXEC;
                end
                S_EXEC: if (!stall) begin
                    r_pc         <= {w_next_pc[31:2], 2'b00};
                    r_icount     <= r_icount + 32'd1;
                    r_inst_valid <= 1'b0;
                    r_req        <= 1'b1;
                    r_state      <= S_FETCH;
                    if (|w_next_pc[1:0]) r_misalign <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule
